scs8hd_o32ai_bist: RTL and testbench

Self-test sequencer for the o32ai cell family: on request it drives all 32 input combinations onto a cell's A1/A2/A3/B1/B2 pins and waits a programmable settle time. It then samples the cell's Y output and compares it against the golden function Y = !((A1|A2|A3) & (B1|B2)). The block is both the stimulus stage feeding the cell and the capture stage consuming Y, and it reports pass/fail, error count and first failing vector to the test controller.

---
 rtl/scs8hd_bist_pkg.sv | 25 ++
 rtl/scs8hd_bist_settle_timer.sv | 31 +++
 rtl/scs8hd_o32ai_bist.sv | 172 +++++++++++++++++
 tb/tb_scs8hd_o32ai_bist.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/scs8hd_bist_pkg.sv
// Shared definitions for the scs8hd cell BIST sequencers: state encoding,
// vector/pin mapping and golden cell functions.
package scs8hd_bist_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } bist_state_e;

  localparam int NUM_VEC = 32;
  localparam int VEC_W   = 5;

  // Bit position of each cell pin within the vector index
  localparam int PIN_A1 = 0;
  localparam int PIN_A2 = 1;
  localparam int PIN_A3 = 2;
  localparam int PIN_B1 = 3;
  localparam int PIN_B2 = 4;

  function automatic logic o32ai_golden(input logic [VEC_W-1:0] v);
    return ~((v[PIN_A1] | v[PIN_A2] | v[PIN_A3]) & (v[PIN_B1] | v[PIN_B2]));
  endfunction

endpackage

// File: rtl/scs8hd_bist_settle_timer.sv
// Per-vector settle counter: counts 0..SETTLE_CYCLES and strobes sample_now
// on the final count, wrapping to 0 so it can be reused for the next vector.
module scs8hd_bist_settle_timer #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic sample_now
);

  localparam int CNT_W = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

  logic [CNT_W-1:0] cnt_r;

  assign sample_now = (cnt_r == CNT_LAST);

  // Settle count register; wraps on the sample strobe
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (sample_now) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_r + CNT_ONE;
    end
  end

endmodule

// File: rtl/scs8hd_o32ai_bist.sv
// Self-test sequencer for the o32ai cell: walks all 32 input vectors, samples
// Y after a settle time and reports pass/fail, error count and first failure.
module scs8hd_o32ai_bist
  import scs8hd_bist_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 6
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic             ABORT,
  output logic             A1,
  output logic             A2,
  output logic             A3,
  output logic             B1,
  output logic             B2,
  input  logic             Y,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic [ERR_W-1:0] ERR_CNT,
  output logic [4:0]       FAIL_VEC,
  output logic             FAIL_VALID
);

  localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VEC - 1);
  localparam logic [VEC_W-1:0] VEC_ONE  = VEC_W'(1'b1);
  localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};
  localparam logic [ERR_W-1:0] ERR_ONE  = ERR_W'(1'b1);

  bist_state_e      state_r, state_nx;
  logic [VEC_W-1:0] vec_r, vec_nx;
  logic [VEC_W-1:0] pins_r, pins_nx;
  logic             busy_r, busy_nx;
  logic             done_r, done_nx;
  logic             pass_r, pass_nx;
  logic [ERR_W-1:0] err_r, err_nx;
  logic [VEC_W-1:0] fvec_r, fvec_nx;
  logic             fvalid_r, fvalid_nx;

  logic             sample_now_s;
  logic             timer_clear_s;
  logic             mismatch_s;
  logic [ERR_W-1:0] err_inc_s;

  // The timer idles at 0 outside RUN so each run starts with a full settle window
  assign timer_clear_s = (state_r != RUN);

  scs8hd_bist_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle_timer (
    .clk        (CLK),
    .reset      (RESET),
    .clear      (timer_clear_s),
    .sample_now (sample_now_s)
  );

  assign mismatch_s = (state_r == RUN) && sample_now_s && (Y != o32ai_golden(vec_r));
  assign err_inc_s  = (err_r == ERR_MAX) ? err_r : (err_r + ERR_ONE);

  // Next-state and next-output decode
  always_comb begin
    state_nx  = state_r;
    vec_nx    = vec_r;
    err_nx    = err_r;
    fvec_nx   = fvec_r;
    fvalid_nx = fvalid_r;
    pass_nx   = pass_r;
    done_nx   = 1'b0;

    case (state_r)
      IDLE: begin
        if (START && !ABORT) begin
          state_nx  = RUN;
          vec_nx    = {VEC_W{1'b0}};
          err_nx    = {ERR_W{1'b0}};
          fvec_nx   = {VEC_W{1'b0}};
          fvalid_nx = 1'b0;
          pass_nx   = 1'b0;
        end else begin
          state_nx = IDLE;
        end
      end
      RUN: begin
        if (ABORT) begin
          state_nx = IDLE;
        end else if (sample_now_s) begin
          if (mismatch_s) begin
            err_nx = err_inc_s;
            if (!fvalid_r) begin
              fvec_nx   = vec_r;
              fvalid_nx = 1'b1;
            end else begin
              fvec_nx = fvec_r;
            end
          end else begin
            err_nx = err_r;
          end
          // PASS reflects the count including this final sample
          if (vec_r == LAST_VEC) begin
            state_nx = FIN;
            done_nx  = 1'b1;
            pass_nx  = (err_nx == {ERR_W{1'b0}});
          end else begin
            vec_nx = vec_r + VEC_ONE;
          end
        end else begin
          state_nx = RUN;
        end
      end
      FIN: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase

    busy_nx = (state_nx == RUN);
    if (state_nx == RUN) begin
      pins_nx = vec_nx;
    end else begin
      pins_nx = {VEC_W{1'b0}};
    end
  end

  // State register
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // Datapath and output registers; pins are registered so they never glitch
  always_ff @(posedge CLK) begin
    if (RESET) begin
      vec_r    <= {VEC_W{1'b0}};
      pins_r   <= {VEC_W{1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      pass_r   <= 1'b0;
      err_r    <= {ERR_W{1'b0}};
      fvec_r   <= {VEC_W{1'b0}};
      fvalid_r <= 1'b0;
    end else begin
      vec_r    <= vec_nx;
      pins_r   <= pins_nx;
      busy_r   <= busy_nx;
      done_r   <= done_nx;
      pass_r   <= pass_nx;
      err_r    <= err_nx;
      fvec_r   <= fvec_nx;
      fvalid_r <= fvalid_nx;
    end
  end

  assign A1         = pins_r[PIN_A1];
  assign A2         = pins_r[PIN_A2];
  assign A3         = pins_r[PIN_A3];
  assign B1         = pins_r[PIN_B1];
  assign B2         = pins_r[PIN_B2];
  assign BUSY       = busy_r;
  assign DONE       = done_r;
  assign PASS       = pass_r;
  assign ERR_CNT    = err_r;
  assign FAIL_VEC   = fvec_r;
  assign FAIL_VALID = fvalid_r;

endmodule

// File: tb/tb_scs8hd_o32ai_bist.sv
// Scoreboard bench for scs8hd_o32ai_bist: a cell model (or stuck-at fault)
// answers on Y, expected run results are queued at START and checked at DONE.
module tb_scs8hd_o32ai_bist;

  typedef struct {
    int         lat;
    logic       pass;
    logic [5:0] err;
    logic [4:0] fv;
    logic       fvv;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, abort;
  logic       a1, a2, a3, b1, b2, y_s, busy, done, pass, fvalid;
  logic [5:0] err_cnt;
  logic [4:0] fail_vec;
  logic       a1_4, a2_4, a3_4, b1_4, b2_4, y4_s, busy_4, done_4, pass_4, fvalid_4;
  logic [3:0] err_cnt_4;
  logic [4:0] fail_vec_4;

  int   mode = 0;   // 0: correct cell, 1: Y stuck-at-1, 2: Y stuck-at-0
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];

  wire [4:0] pins   = {b2, b1, a3, a2, a1};
  wire [4:0] pins_4 = {b2_4, b1_4, a3_4, a2_4, a1_4};

  function automatic logic ref_y(input logic [4:0] v);
    logic any_a;
    logic any_b;
    any_a = v[0] | v[1] | v[2];
    any_b = v[3] | v[4];
    return !(any_a && any_b);
  endfunction

  assign y_s  = (mode == 0) ? ref_y(pins)   : (mode == 1);
  assign y4_s = (mode == 0) ? ref_y(pins_4) : (mode == 1);

  always @(posedge clk) cyc <= cyc + 1;

  scs8hd_o32ai_bist dut (
    .CLK(clk), .RESET(reset), .START(start), .ABORT(abort),
    .A1(a1), .A2(a2), .A3(a3), .B1(b1), .B2(b2), .Y(y_s),
    .BUSY(busy), .DONE(done), .PASS(pass), .ERR_CNT(err_cnt),
    .FAIL_VEC(fail_vec), .FAIL_VALID(fvalid)
  );

  scs8hd_o32ai_bist #(.SETTLE_CYCLES(2), .ERR_W(4)) dut4 (
    .CLK(clk), .RESET(reset), .START(start), .ABORT(abort),
    .A1(a1_4), .A2(a2_4), .A3(a3_4), .B1(b1_4), .B2(b2_4), .Y(y4_s),
    .BUSY(busy_4), .DONE(done_4), .PASS(pass_4), .ERR_CNT(err_cnt_4),
    .FAIL_VEC(fail_vec_4), .FAIL_VALID(fvalid_4)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected outcome of a full run against the chosen Y behaviour
  task automatic push_expect(input int m);
    exp_t e;
    logic yv;
    e.lat = 96; e.err = 6'd0; e.fv = 5'd0; e.fvv = 1'b0;
    for (int v = 0; v < 32; v++) begin
      yv = (m == 0) ? ref_y(5'(v)) : (m == 1);
      if (yv != ref_y(5'(v))) begin
        if (e.err != 6'd63) e.err = e.err + 6'd1;
        if (!e.fvv) begin
          e.fv  = 5'(v);
          e.fvv = 1'b1;
        end
      end
    end
    e.pass = (e.err == 6'd0);
    sb.push_back(e);
  endtask

  task automatic start_run(input int m, output int k);
    mode  = m;
    start = 1'b1;
    tick();
    start = 1'b0;
    k = cyc;
  endtask

  task automatic run_and_check(input int m, input bit pulse_mid);
    int   k;
    bit   seen;
    exp_t e;
    int   e4;
    seen = 1'b0;
    push_expect(m);
    start_run(m, k);
    check_val("busy_at_accept", busy, 1);
    check_val("pins_vec0", pins, 0);
    for (int i = 1; i <= 200 && !seen; i++) begin
      if (pulse_mid && i == 30) start = 1'b1;
      tick();
      start = 1'b0;
      if (i == 4) check_val("pins_vec1", pins, 1);
      if (done) begin
        seen = 1'b1;
        e = sb.pop_front();
        check_val("done_latency", cyc - k, e.lat);
        check_val("busy_at_done", busy, 0);
        check_val("pass", pass, e.pass);
        check_val("err_cnt", err_cnt, e.err);
        check_val("fail_vec", fail_vec, e.fv);
        check_val("fail_valid", fvalid, e.fvv);
        if (m == 1) begin
          e4 = (e.err > 6'd15) ? 15 : int'(e.err);
          check_val("err_cnt_w4_sat", err_cnt_4, e4);
          check_val("fail_vec_w4", fail_vec_4, e.fv);
        end
      end
    end
    if (!seen) begin
      check_val("done_timeout", 0, 1);
      if (sb.size() > 0) e = sb.pop_front();
    end
    tick();
    check_val("done_one_cycle", done, 0);
    check_val("pass_held", pass, (m == 0));
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_pins"}, pins, 0);
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_done"}, done, 0);
    check_val({tag, "_pass"}, pass, 0);
    check_val({tag, "_err"}, err_cnt, 0);
    check_val({tag, "_fvec"}, fail_vec, 0);
    check_val({tag, "_fvalid"}, fvalid, 0);
  endtask

  initial begin
    int k;
    int n_done;
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    check_all_zero("reset");

    // START and ABORT together in IDLE: stays idle
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check_val("start_abort_idle", busy, 0);
    tick();

    run_and_check(0, 1'b0);
    repeat (3) tick();
    run_and_check(1, 1'b0);
    repeat (3) tick();
    run_and_check(2, 1'b0);
    repeat (3) tick();

    // Abort 40 cycles in: idle next edge, no DONE, partial results kept
    start_run(0, k);
    repeat (39) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_val("abort_busy", busy, 0);
    check_val("abort_pins", pins, 0);
    check_val("abort_pass", pass, 0);
    n_done = 0;
    for (int i = 0; i < 120; i++) begin
      tick();
      if (done) n_done++;
    end
    check_val("abort_no_done", n_done, 0);
    run_and_check(0, 1'b0);
    repeat (3) tick();

    // Reset 50 cycles into a stuck-at-1 run (errors already accumulated)
    start_run(1, k);
    repeat (50) tick();
    check_val("pre_reset_fvalid", fvalid, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_all_zero("mid_reset");
    repeat (3) tick();

    // START pulsed mid-run must not restart or lengthen the run
    run_and_check(0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
